// File: rtl/i2c_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter_if
// Bundles the requester-side and engine-side signals of the I2C master
// arbiter.
//
// Signals:
//   Requester side:
//     req        level request per requester, held until its done pulse
//     req_rw     per requester, 1 = read and 0 = write
//     req_addr   device address byte per requester (slice i = [8i+7:8i])
//     req_offset register offset byte per requester
//     req_wdata  write data byte per requester
//     gnt        one-hot grant
//     done       one-cycle completion pulse
//     rsp_rdata  read byte returned with done
//     rsp_err    completion status: 00 ok, 01 nack, 10 timeout
//   Engine side:
//     m_start    command strobe
//     m_read     read select
//     m_write    write select
//     m_address  device address
//     m_offset   register offset
//     m_wdata    write data
//     m_abort    abort strobe
//     m_busy     engine busy
//     m_done     engine completion pulse
//     m_nack     NACK flag, sampled with m_done
//     m_rdata    read byte, sampled with m_done
//
// Modports:
//   master  the arbiter, which sequences commands into the engine
//   slave   the environment, i.e. the requesters plus the engine
// ---------------------------------------------------------------------------
interface i2c_master_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_offset;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rsp_rdata;
  logic [1:0]           rsp_err;
  logic                 m_start;
  logic                 m_read;
  logic                 m_write;
  logic [7:0]           m_address;
  logic [7:0]           m_offset;
  logic [7:0]           m_wdata;
  logic                 m_abort;
  logic                 m_busy;
  logic                 m_done;
  logic                 m_nack;
  logic [7:0]           m_rdata;

  modport master (
    input  req, req_rw, req_addr, req_offset, req_wdata,
    input  m_busy, m_done, m_nack, m_rdata,
    output gnt, done, rsp_rdata, rsp_err,
    output m_start, m_read, m_write, m_address, m_offset, m_wdata, m_abort
  );

  modport slave (
    output req, req_rw, req_addr, req_offset, req_wdata,
    output m_busy, m_done, m_nack, m_rdata,
    input  gnt, done, rsp_rdata, rsp_err,
    input  m_start, m_read, m_write, m_address, m_offset, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
// Round-robin arbiter/sequencer that shares one I2C master engine among
// NUM_REQ requesters. Each requester posts a single-byte read or write.
//
// Operation:
//   - One requester is granted and its command is latched.
//   - The engine receives a start strobe.
//   - The arbiter then waits for the engine's done, or for a watchdog timeout.
//   - The read data and status are returned with a one-cycle done pulse.
//
// Ports:
//   SYSTEM_CLK  system clock; all logic runs on its rising edge
//   RESET       asynchronous, active-high reset
//   bus         i2c_master_arbiter_if.master. It carries the requester
//               req/done handshake and the engine m_* command/response
//               signals.
//
// Parameters:
//   NUM_REQ         number of requesters, 2..8
//   TIMEOUT_CYCLES  number of WAIT cycles before the engine is aborted (>= 2)
// ---------------------------------------------------------------------------
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  SYSTEM_CLK,
  input logic                  RESET,
  i2c_master_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   gidx_r;
  logic [TMR_W-1:0]   timer_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic [7:0]         rsp_rdata_r;
  logic [1:0]         rsp_err_r;
  logic               m_start_r;
  logic               m_read_r;
  logic               m_write_r;
  logic [7:0]         m_address_r;
  logic [7:0]         m_offset_r;
  logic [7:0]         m_wdata_r;
  logic               m_abort_r;
  logic [IDX_W-1:0]   pick_idx_s;

  // Next round-robin start position: one past the given index, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
  endfunction

  // Round-robin pick: first set request at or after rr_ptr_r, wrapping around.
  always_comb begin
    logic          found_v;
    logic [CW-1:0] cand_v;
    found_v    = 1'b0;
    cand_v     = {CW{1'b0}};
    pick_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_v = CW'(rr_ptr_r) + CW'(i);
      cand_v = (cand_v >= CW'(NUM_REQ)) ? (cand_v - CW'(NUM_REQ)) : cand_v;
      if (!found_v && bus.req[cand_v[IDX_W-1:0]]) begin
        found_v    = 1'b1;
        pick_idx_s = cand_v[IDX_W-1:0];
      end else begin
        found_v = found_v;
      end
    end
  end

  // Sequencing FSM; every output toward requesters and engine is a register here.
  always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= {IDX_W{1'b0}};
      gidx_r      <= {IDX_W{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
      gnt_r       <= {NUM_REQ{1'b0}};
      done_r      <= {NUM_REQ{1'b0}};
      rsp_rdata_r <= 8'h00;
      rsp_err_r   <= 2'b00;
      m_start_r   <= 1'b0;
      m_read_r    <= 1'b0;
      m_write_r   <= 1'b0;
      m_address_r <= 8'h00;
      m_offset_r  <= 8'h00;
      m_wdata_r   <= 8'h00;
      m_abort_r   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      m_start_r <= 1'b0;
      m_abort_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|bus.req) begin
            state_r     <= ST_GRANT;
            gidx_r      <= pick_idx_s;
            gnt_r       <= ONE_HOT0 << pick_idx_s;
            m_read_r    <= bus.req_rw[pick_idx_s];
            m_write_r   <= ~bus.req_rw[pick_idx_s];
            m_address_r <= bus.req_addr[{pick_idx_s, 3'b000} +: 8];
            m_offset_r  <= bus.req_offset[{pick_idx_s, 3'b000} +: 8];
            m_wdata_r   <= bus.req_wdata[{pick_idx_s, 3'b000} +: 8];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Hold the command until the engine is free; the strobe goes out in ISSUE.
          if (!bus.m_busy) begin
            state_r   <= ST_ISSUE;
            m_start_r <= 1'b1;
          end else begin
            state_r <= ST_GRANT;
          end
        end
        ST_ISSUE: begin
          timer_r <= {TMR_W{1'b0}};
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion in the terminal-count cycle takes priority over the abort.
          if (bus.m_done) begin
            rsp_rdata_r <= (m_read_r && !bus.m_nack) ? bus.m_rdata : 8'h00;
            rsp_err_r   <= bus.m_nack ? 2'b01 : 2'b00;
            done_r      <= gnt_r;
            state_r     <= ST_DONE;
          end else if (timer_r == TMR_LAST) begin
            m_abort_r   <= 1'b1;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 2'b10;
            done_r      <= gnt_r;
            state_r     <= ST_DONE;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          done_r    <= {NUM_REQ{1'b0}};
          gnt_r     <= {NUM_REQ{1'b0}};
          m_read_r  <= 1'b0;
          m_write_r <= 1'b0;
          rr_ptr_r  <= wrap_inc(gidx_r);
          state_r   <= ST_IDLE;
        end
        default: begin
          done_r    <= {NUM_REQ{1'b0}};
          gnt_r     <= {NUM_REQ{1'b0}};
          m_read_r  <= 1'b0;
          m_write_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.m_start   = m_start_r;
  assign bus.m_read    = m_read_r;
  assign bus.m_write   = m_write_r;
  assign bus.m_address = m_address_r;
  assign bus.m_offset  = m_offset_r;
  assign bus.m_wdata   = m_wdata_r;
  assign bus.m_abort   = m_abort_r;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_arbiter
// Self-checking bench for i2c_master_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=64).
// A transaction-level reference model supplies every expectation:
//   - the round-robin winner
//   - start latency from busy cycles
//   - done latency and status from the engine response cycle
// Inputs are driven at the falling edge, and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_i2c_master_arbiter;

  localparam int TMO = 64;

  logic clk;
  logic rst;

  i2c_master_arbiter_if #(.NUM_REQ(4)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ       (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .SYSTEM_CLK(clk),
    .RESET     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ptr_m    = 0;
  logic [7:0] addr_a[4];
  logic [7:0] off_a[4];
  logic [7:0] wd_a[4];
  logic [3:0] rw_v;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {18'd0, bus.gnt, bus.done, bus.rsp_rdata, bus.rsp_err, bus.m_start, bus.m_read,
            bus.m_write, bus.m_address, bus.m_offset, bus.m_wdata, bus.m_abort};
  endfunction

  task automatic pack_fields();
    bus.req_rw = rw_v;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*8 +: 8]   = addr_a[i];
      bus.req_offset[i*8 +: 8] = off_a[i];
      bus.req_wdata[i*8 +: 8]  = wd_a[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 8'($urandom);
      off_a[i]  = 8'($urandom);
      wd_a[i]   = 8'($urandom);
    end
    rw_v = 4'($urandom);
    pack_fields();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    bus.req    = 4'b0000;
    bus.m_done = 1'b0;
    bus.m_busy = 1'b0;
    #1 check_val("reset_outs", outs_vec(), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  // One full transaction, started at a falling edge while the arbiter is idle.
  // Arguments:
  //   resp    WAIT cycle (1-based) in which the engine pulses m_done; values
  //           outside 1..TMO mean no response in time
  //   stray   pulse m_done during GRANT, where the arbiter must ignore it
  //   mutate  scramble all req_* inputs right after the grant
  task automatic run_txn(input logic [3:0] reqv, input int busy_cyc, input int resp,
                         input logic nack, input logic [7:0] rdata, input logic stray,
                         input logic mutate);
    int         w;
    int         s;
    int         done_at;
    int         exp_done;
    int         aborts;
    logic       resp_ok;
    logic       exp_rw;
    logic [3:0] oh;
    logic [7:0] ea;
    logic [7:0] eo;
    logic [7:0] ew;
    logic [7:0] exp_rd;
    logic [1:0] exp_err;

    w = 0;
    for (int i = 3; i >= 0; i--) begin
      if (reqv[(ptr_m + i) % 4]) w = (ptr_m + i) % 4;
    end
    oh       = 4'b0001 << w;
    exp_rw   = rw_v[w];
    ea       = addr_a[w];
    eo       = off_a[w];
    ew       = wd_a[w];
    resp_ok  = (resp >= 1) && (resp <= TMO);
    exp_done = resp_ok ? resp + 1 : TMO + 1;
    exp_err  = resp_ok ? (nack ? 2'b01 : 2'b00) : 2'b10;
    exp_rd   = (resp_ok && exp_rw && !nack) ? rdata : 8'h00;

    pack_fields();
    bus.req    = reqv;
    bus.m_busy = (busy_cyc > 0);

    s = -1;
    for (int n = 1; n <= busy_cyc + 6 && s < 0; n++) begin
      @(negedge clk);
      if (bus.m_start) s = n;
      bus.m_done = 1'b0;
      if (n == 1) begin
        check_val("grant_onehot", bus.gnt, oh);
        check_val("grant_cmd", {bus.m_read, bus.m_write, bus.m_address, bus.m_offset, bus.m_wdata},
                  {exp_rw, ~exp_rw, ea, eo, ew});
        if (mutate) begin
          rand_fields();
          bus.req = 4'($urandom);
        end
        bus.m_done = stray;
      end
      if (n == busy_cyc + 1) bus.m_busy = 1'b0;
    end
    check_val("start_latency", s, 2 + busy_cyc);
    if (s < 0) begin
      do_reset();
      return;
    end
    check_val("start_cmd", {bus.gnt, bus.m_read, bus.m_write, bus.m_address, bus.m_offset, bus.m_wdata},
              {oh, exp_rw, ~exp_rw, ea, eo, ew});

    done_at = -1;
    aborts  = 0;
    for (int j = 1; j <= TMO + 6 && done_at < 0; j++) begin
      @(negedge clk);
      if (j == 1) check_val("start_width", bus.m_start, 1'b0);
      if (bus.done != 4'b0000) begin
        done_at = j;
        check_val("done_vec", bus.done, oh);
        check_val("done_gnt", bus.gnt, oh);
        check_val("rsp_err", bus.rsp_err, exp_err);
        check_val("rsp_rdata", bus.rsp_rdata, exp_rd);
        check_val("abort_at_done", bus.m_abort, !resp_ok);
      end else if (bus.m_abort) begin
        aborts++;
      end
      bus.m_done  = (j == resp);
      bus.m_nack  = (j == resp) ? nack : 1'($urandom);
      bus.m_rdata = (j == resp) ? rdata : 8'($urandom);
    end
    check_val("done_latency", done_at, exp_done);
    check_val("early_abort", aborts, 0);
    if (done_at < 0) begin
      do_reset();
      return;
    end

    @(negedge clk);
    check_val("post_done_clear", {bus.done, bus.gnt, bus.m_read, bus.m_write, bus.m_abort, bus.m_start},
              64'd0);
    check_val("rsp_hold", {bus.rsp_err, bus.rsp_rdata}, {exp_err, exp_rd});
    bus.m_done = 1'b0;
    ptr_m      = (w + 1) % 4;
  endtask

  // Reset mid-transaction: all outputs drop at once, and no done follows.
  task automatic reset_mid();
    int s;
    int n_done;
    rand_fields();
    rw_v[1] = 1'b1;
    pack_fields();
    bus.req    = 4'b0010;
    bus.m_busy = 1'b0;
    s = -1;
    for (int n = 1; n <= 6 && s < 0; n++) begin
      @(negedge clk);
      if (bus.m_start) s = n;
    end
    check_val("rst_mid_start", s, 2);
    repeat (3) @(negedge clk);
    check_val("rst_mid_gnt_before", bus.gnt, 4'b0010);
    #2 rst = 1'b1;
    #1 check_val("rst_mid_async", outs_vec(), 64'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    rst    = 1'b0;
    ptr_m  = 0;
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done != 4'b0000) n_done++;
    end
    check_val("rst_mid_no_done", n_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst           = 1'b1;
    bus.req       = 4'b0000;
    bus.m_busy    = 1'b0;
    bus.m_done    = 1'b0;
    bus.m_nack    = 1'b0;
    bus.m_rdata   = 8'h00;
    rand_fields();
    repeat (2) @(negedge clk);
    check_val("reset_state", outs_vec(), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write to requester 0
    addr_a[0] = 8'h46;
    off_a[0]  = 8'h5A;
    wd_a[0]   = 8'hA0;
    rw_v      = 4'b0000;
    run_txn(4'b0001, 0, 3, 1'b0, 8'h5C, 1'b0, 1'b0);

    // Single read from requester 2, inputs scrambled after the grant
    rw_v[2] = 1'b1;
    run_txn(4'b0100, 0, 2, 1'b0, 8'hA0, 1'b0, 1'b1);

    // Fairness from a fresh pointer
    do_reset();
    repeat (4) run_txn(4'b1111, 0, 1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    repeat (4) run_txn(4'b1001, 0, 2, 1'b0, 8'($urandom), 1'b0, 1'b0);

    // NACK on a read, with a stray m_done during GRANT
    rw_v = 4'b1111;
    run_txn(4'b0010, 1, 4, 1'b1, 8'h77, 1'b1, 1'b0);

    // Timeout, a coincident m_done at terminal count, and a late m_done
    run_txn(4'b1000, 0, -1, 1'b0, 8'h11, 1'b0, 1'b0);
    run_txn(4'b0100, 0, TMO, 1'b0, 8'h3C, 1'b0, 1'b0);
    run_txn(4'b0001, 0, TMO + 1, 1'b0, 8'h5E, 1'b0, 1'b0);

    // Engine busy for 10 cycles in GRANT
    run_txn(4'b0010, 10, 5, 1'b0, 8'hC3, 1'b0, 1'b0);

    reset_mid();

    for (int t = 0; t < 40; t++) begin
      int cat;
      int resp;
      int busy;
      rand_fields();
      busy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      cat  = int'($urandom_range(0, 9));
      resp = (cat < 7) ? int'($urandom_range(1, 8)) : (cat == 7) ? TMO : (cat == 8) ? -1 : TMO - 1;
      run_txn(4'($urandom_range(1, 15)), busy, resp, 1'($urandom), 8'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
